// File: rtl/uart_rx_frame_counter.sv
// uart_rx_frame_counter
// Oversampling edge/bit counter for the UART receiver. Counts clocks within a
// bit and bits within a frame, and decodes the three mid-bit majority-vote
// sample strobes plus the bit-done and frame-done pulses. Prescale and frame
// format are taken live while idle and frozen for the duration of a frame.
module uart_rx_frame_counter #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4,
  parameter int MIN_PRESCALE   = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cnt_en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [1:0]                data_bits,
  input  logic                      par_en,
  input  logic                      stop2,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic [2:0]                sample_strb,
  output logic                      bit_done,
  output logic                      frame_done,
  output logic                      cfg_err,
  output logic                      busy
);

  localparam int PW = PRESCALE_WIDTH;
  localparam int BW = BIT_CNT_WIDTH;
  localparam logic [PW-1:0] EDGE_ONE = PW'(1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   edge_d;
  logic [BW-1:0]   bit_d;
  logic            load;

  // Frame configuration frozen at the start of a frame
  logic [PW-1:0]   pre_q;
  logic [1:0]      dbits_q;
  logic            par_q;
  logic            stop2_q;

  // Effective configuration and derived decode points
  logic [PW-1:0]   p_eff;
  logic [PW-1:0]   p_last;
  logic [PW-1:0]   half;
  logic [1:0]      dbits_eff;
  logic            par_eff;
  logic            stop2_eff;
  logic [BW-1:0]   fl_last;
  logic            active;

  // A prescale is unusable if it is too small or odd (no symmetric mid-bit).
  function automatic logic prescale_illegal(input logic [PW-1:0] p);
    return (p < PW'(MIN_PRESCALE)) || p[0];
  endfunction

  // Index of the last bit of the frame: start + data + parity + stop(s) - 1.
  function automatic logic [BW-1:0] frame_last(input logic [1:0] db,
                                               input logic       par,
                                               input logic       s2);
    return BW'(6) + BW'(db) + BW'(par) + BW'(s2);
  endfunction

  assign p_eff     = (state_q == IDLE) ? prescale  : pre_q;
  assign dbits_eff = (state_q == IDLE) ? data_bits : dbits_q;
  assign par_eff   = (state_q == IDLE) ? par_en    : par_q;
  assign stop2_eff = (state_q == IDLE) ? stop2     : stop2_q;

  assign p_last  = p_eff - EDGE_ONE;
  assign half    = p_eff >> 1;
  assign fl_last = frame_last(dbits_eff, par_eff, stop2_eff);

  // Pulses only exist while counting is enabled, outside HOLD, with a usable
  // prescale; an illegal prescale in IDLE must never produce strobes.
  assign cfg_err    = prescale_illegal(p_eff);
  assign active     = cnt_en && (state_q != HOLD) && !cfg_err;
  assign bit_done   = active && (edge_cnt == p_last);
  assign frame_done = bit_done && (bit_cnt == fl_last);

  assign sample_strb[0] = active && (edge_cnt == (half - PW'(2)));
  assign sample_strb[1] = active && (edge_cnt == (half - EDGE_ONE));
  assign sample_strb[2] = active && (edge_cnt == half);

  assign busy = (state_q == COUNT);

  // Next-state and next-counter selection; cnt_en low is a synchronous clear.
  always_comb begin
    state_d = state_q;
    edge_d  = edge_cnt;
    bit_d   = bit_cnt;
    load    = 1'b0;
    if (!cnt_en) begin
      state_d = IDLE;
      edge_d  = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          edge_d = '0;
          bit_d  = '0;
          if (!cfg_err) begin
            // The idle cycle itself is edge 0 of bit 0.
            load    = 1'b1;
            state_d = COUNT;
            edge_d  = EDGE_ONE;
          end
        end
        COUNT: begin
          if (frame_done) begin
            state_d = HOLD;
            edge_d  = '0;
            bit_d   = '0;
          end else if (edge_cnt == p_last) begin
            edge_d = '0;
            bit_d  = bit_cnt + BIT_ONE;
          end else begin
            edge_d = edge_cnt + EDGE_ONE;
          end
        end
        HOLD: begin
          edge_d = '0;
          bit_d  = '0;
        end
        default: begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  // State, counters and frozen configuration registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      pre_q    <= '0;
      dbits_q  <= '0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_cnt <= edge_d;
      bit_cnt  <= bit_d;
      if (load) begin
        pre_q   <= prescale;
        dbits_q <= data_bits;
        par_q   <= par_en;
        stop2_q <= stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// tb_uart_rx_frame_counter
// Self-checking bench: a behavioural model tracks frame position as a plain
// clock count since frame start and derives edge/bit/strobes arithmetically.
module tb_uart_rx_frame_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cnt_en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [1:0] data_bits = 2'd3;
  logic       par_en = 1'b0;
  logic       stop2 = 1'b0;

  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [2:0] sample_strb;
  logic       bit_done;
  logic       frame_done;
  logic       cfg_err;
  logic       busy;

  uart_rx_frame_counter #(
    .PRESCALE_WIDTH(6),
    .BIT_CNT_WIDTH (4),
    .MIN_PRESCALE  (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cnt_en     (cnt_en),
    .prescale   (prescale),
    .data_bits  (data_bits),
    .par_en     (par_en),
    .stop2      (stop2),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .sample_strb(sample_strb),
    .bit_done   (bit_done),
    .frame_done (frame_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: mode 0 idle, 1 counting, 2 holding after a completed frame.
  int m_mode = 0;
  int m_t = 0;
  int m_P = 0;
  int m_FL = 0;
  int cur_P, cur_FL;
  bit cur_ill;

  int         e_edge, e_bit;
  logic [2:0] e_strb;
  logic       e_bd, e_fd, e_cfg, e_busy;

  int         obs_edge, obs_bit;
  logic [2:0] obs_strb;
  logic       obs_bd, obs_fd, obs_cfg, obs_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_eval();
    bit act;
    cur_P   = (m_mode == 0) ? int'(prescale) : m_P;
    cur_FL  = (m_mode == 0) ? (7 + int'(data_bits) + int'(par_en) + int'(stop2)) : m_FL;
    cur_ill = (cur_P < 4) || (cur_P % 2 != 0);
    if (m_mode == 1) begin
      e_edge = m_t % cur_P;
      e_bit  = m_t / cur_P;
    end else begin
      e_edge = 0;
      e_bit  = 0;
    end
    act    = cnt_en && (m_mode != 2) && !cur_ill;
    e_bd   = act && (e_edge == cur_P - 1);
    e_fd   = e_bd && (e_bit == cur_FL - 1);
    for (int i = 0; i < 3; i++) e_strb[i] = act && (e_edge == cur_P / 2 - 2 + i);
    e_cfg  = cur_ill;
    e_busy = (m_mode == 1);
  endtask

  task automatic model_step();
    if (!cnt_en) begin
      m_mode = 0;
      m_t = 0;
    end else if (m_mode == 0) begin
      if (!cur_ill) begin
        m_P = cur_P;
        m_FL = cur_FL;
        m_mode = 1;
        m_t = 1;
      end
    end else if (m_mode == 1) begin
      if (e_fd) begin
        m_mode = 2;
        m_t = 0;
      end else begin
        m_t++;
      end
    end
  endtask

  // One clock: drive inputs after the falling edge, compare, then advance model.
  task automatic step(input bit en, input int p, input int db, input bit par, input bit s2);
    @(negedge CLK);
    cnt_en = en;
    prescale = p[5:0];
    data_bits = db[1:0];
    par_en = par;
    stop2 = s2;
    #1;
    model_eval();
    check("edge_cnt", edge_cnt, e_edge);
    check("bit_cnt", bit_cnt, e_bit);
    check("sample_strb", sample_strb, e_strb);
    check("bit_done", bit_done, e_bd);
    check("frame_done", frame_done, e_fd);
    check("cfg_err", cfg_err, e_cfg);
    check("busy", busy, e_busy);
    obs_edge = edge_cnt;
    obs_bit  = bit_cnt;
    obs_strb = sample_strb;
    obs_bd   = bit_done;
    obs_fd   = frame_done;
    obs_cfg  = cfg_err;
    obs_busy = busy;
    @(posedge CLK);
    if (RST) model_step();
    cyc++;
  endtask

  task automatic run_frame(input int p, input int db, input bit par, input bit s2, input int n,
                           output int fd_at, output int s0, output int s1, output int s2e,
                           output int nbd);
    fd_at = -1; s0 = -1; s1 = -1; s2e = -1; nbd = 0;
    for (int k = 0; k < n; k++) begin
      step(1'b1, p, db, par, s2);
      if (obs_fd && fd_at < 0) fd_at = k;
      if (obs_bd) nbd++;
      if (obs_strb[0] && s0 < 0) s0 = obs_edge;
      if (obs_strb[1] && s1 < 0) s1 = obs_edge;
      if (obs_strb[2] && s2e < 0) s2e = obs_edge;
    end
  endtask

  initial begin
    int fd_at, s0, s1, s2e, nbd;
    int p, db, en;
    bit par, s2;

    // Reset state
    #3;
    check("rst_edge", edge_cnt, 0);
    check("rst_bit", bit_cnt, 0);
    check("rst_strb", sample_strb, 0);
    check("rst_bd", bit_done, 0);
    check("rst_fd", frame_done, 0);
    check("rst_cfg", cfg_err, 0);
    check("rst_busy", busy, 0);
    @(negedge CLK);
    #2 RST = 1'b1;

    // P=8, 8N1
    run_frame(8, 3, 0, 0, 80, fd_at, s0, s1, s2e, nbd);
    check("8n1_fd_cycle", fd_at, 79);
    check("8n1_fd_bit", obs_bit, 9);
    check("8n1_fd_edge", obs_edge, 7);
    check("8n1_strb0", s0, 2);
    check("8n1_strb1", s1, 3);
    check("8n1_strb2", s2e, 4);
    check("8n1_bitdones", nbd, 10);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8, 3, 0, 0);
      check("hold_edge", obs_edge, 0);
      check("hold_strb", obs_strb, 0);
      check("hold_busy", obs_busy, 0);
    end
    step(1'b0, 8, 3, 0, 0);

    // P=16, 7E2
    run_frame(16, 2, 1, 1, 176, fd_at, s0, s1, s2e, nbd);
    check("7e2_fd_cycle", fd_at, 175);
    check("7e2_strb0", s0, 6);
    check("7e2_strb1", s1, 7);
    check("7e2_strb2", s2e, 8);
    check("7e2_bitdones", nbd, 11);
    step(1'b0, 16, 2, 1, 1);

    // Prescale change mid-frame is ignored until the next frame
    fd_at = -1;
    nbd = 0;
    for (int k = 0; k < 100; k++) begin
      step(1'b1, (k >= 24) ? 16 : 8, 3, 0, 0);
      if (obs_fd && fd_at < 0) fd_at = k;
      if (obs_bd) nbd++;
    end
    check("pchg_fd_cycle", fd_at, 79);
    check("pchg_bitdones", nbd, 10);
    step(1'b0, 16, 3, 0, 0);
    run_frame(16, 3, 0, 0, 160, fd_at, s0, s1, s2e, nbd);
    check("pchg_next_fd", fd_at, 159);
    step(1'b0, 8, 3, 0, 0);

    // Abort mid-bit via cnt_en
    for (int k = 0; k < 37; k++) step(1'b1, 8, 3, 0, 0);
    step(1'b0, 8, 3, 0, 0);
    check("abort_at_edge", obs_edge, 5);
    check("abort_at_bit", obs_bit, 4);
    check("abort_no_fd", obs_fd, 0);
    step(1'b0, 8, 3, 0, 0);
    check("abort_edge", obs_edge, 0);
    check("abort_bit", obs_bit, 0);
    check("abort_busy", obs_busy, 0);
    run_frame(8, 3, 0, 0, 80, fd_at, s0, s1, s2e, nbd);
    check("abort_restart_fd", fd_at, 79);
    step(1'b0, 8, 3, 0, 0);

    // Illegal prescales, then P=4
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 5, 3, 0, 0);
      check("p5_cfg_err", obs_cfg, 1);
      check("p5_strb", obs_strb, 0);
      check("p5_edge", obs_edge, 0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2, 3, 0, 0);
      check("p2_cfg_err", obs_cfg, 1);
      check("p2_strb", obs_strb, 0);
      check("p2_busy", obs_busy, 0);
    end
    run_frame(4, 3, 0, 0, 40, fd_at, s0, s1, s2e, nbd);
    check("p4_strb0", s0, 0);
    check("p4_strb1", s1, 1);
    check("p4_strb2", s2e, 2);
    check("p4_fd_cycle", fd_at, 39);
    step(1'b0, 8, 3, 0, 0);

    // Asynchronous reset mid-frame
    for (int k = 0; k < 48; k++) step(1'b1, 8, 3, 0, 0);
    @(negedge CLK);
    #1;
    check("pre_rst_bit", bit_cnt, 6);
    #1 RST = 1'b0;
    #1;
    check("arst_edge", edge_cnt, 0);
    check("arst_bit", bit_cnt, 0);
    check("arst_strb", sample_strb, 0);
    check("arst_bd", bit_done, 0);
    check("arst_fd", frame_done, 0);
    check("arst_cfg", cfg_err, 0);
    check("arst_busy", busy, 0);
    cnt_en = 1'b0;
    m_mode = 0;
    m_t = 0;
    @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
    run_frame(8, 3, 0, 0, 80, fd_at, s0, s1, s2e, nbd);
    check("arst_frame_fd", fd_at, 79);
    check("arst_frame_bd", nbd, 10);
    step(1'b0, 8, 3, 0, 0);

    // Randomized traffic against the model
    en = 1; p = 8; db = 3; par = 0; s2 = 0;
    for (int k = 0; k < 4000; k++) begin
      if (en == 0) begin
        if ($urandom_range(0, 1) == 1) en = 1;
      end else if (obs_fd) begin
        if ($urandom_range(0, 1) == 1) en = 0;
      end else if ($urandom_range(0, 99) == 0) begin
        en = 0;
      end
      if ($urandom_range(0, 99) < 3) begin
        if ($urandom_range(0, 9) == 0) p = int'($urandom_range(0, 63));
        else p = 2 * int'($urandom_range(2, 8));
        db = int'($urandom_range(0, 3));
        par = 1'($urandom_range(0, 1));
        s2 = 1'($urandom_range(0, 1));
      end
      step(en[0], p, db, par, s2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
